// File: rtl/poly_ms_stream.sv
`default_nettype none
// ============================================================================
// Module   : poly_ms_stream
// Purpose  : Sequencer for polynomial-wise modular subtraction
//            c[i] = (a[i] - b[i]) mod q. Issues shared reads to the a/b
//            RAMs, aligns returning data with its address across RD_LAT
//            cycles, computes the result and writes it to the c RAM.
// Revision : 1.0 - initial release
// ============================================================================
module poly_ms_stream #(
  parameter int N      = 256,
  parameter int DW     = 24,
  parameter int AW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [DW-1:0] i_q,
  input  logic [4:0]    i_q_width,
  output logic          o_rd_en,
  output logic [AW-1:0] o_rd_addr,
  input  logic [DW-1:0] i_a_rdata,
  input  logic [DW-1:0] i_b_rdata,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [DW-1:0] o_wr_data,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [1:0]    c_ST_IDLE  = 2'd0;
  localparam logic [1:0]    c_ST_RUN   = 2'd1;
  localparam logic [1:0]    c_ST_DRAIN = 2'd2;
  localparam logic [1:0]    c_ST_DONE  = 2'd3;
  localparam logic [AW-1:0] c_LAST     = AW'(N - 1);
  localparam logic [DW:0]   c_ONE      = (DW+1)'(1);

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_q;
  logic [4:0]    r_qw;
  logic          w_abort;

  // Valid/address delay line: stage RD_LAT-1 lines up with returning rdata
  logic [RD_LAT-1:0] r_vld;
  logic [AW-1:0]     r_vaddr [RD_LAT];

  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [DW-1:0] r_wr_data;

  logic [DW:0]   w_d;
  logic [DW:0]   w_mask;
  logic          w_borrow;
  logic [DW-1:0] w_sum;
  logic [DW-1:0] w_r;

  // Abort only has meaning while an operation is in flight
  assign w_abort = i_abort && (r_state == c_ST_RUN || r_state == c_ST_DRAIN);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE:  if (i_start) w_next = c_ST_RUN;
      c_ST_RUN: begin
        if (i_abort)               w_next = c_ST_IDLE;
        else if (r_addr == c_LAST) w_next = c_ST_DRAIN;
      end
      c_ST_DRAIN: begin
        if (i_abort)                              w_next = c_ST_IDLE;
        else if (r_wr_en && r_wr_addr == c_LAST) w_next = c_ST_DONE;
      end
      default:    w_next = c_ST_IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    o_rd_en   = (r_state == c_ST_RUN);
    o_rd_addr = r_addr;
    o_busy    = (r_state == c_ST_RUN) || (r_state == c_ST_DRAIN);
    o_done    = (r_state == c_ST_DONE);
  end

  // Read address counter; returns to 0 whenever RUN is left
  always_ff @(posedge clk) begin
    if (rst)                                             r_addr <= '0;
    else if (r_state == c_ST_RUN && w_next != c_ST_RUN)  r_addr <= '0;
    else if (r_state == c_ST_RUN)                        r_addr <= r_addr + AW'(1);
  end

  // Modulus and borrow bit index are captured when start is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q  <= '0;
      r_qw <= '0;
    end else if (r_state == c_ST_IDLE && i_start) begin
      r_q  <= i_q;
      r_qw <= i_q_width;
    end
  end

  // Delay line carrying read strobe and address to the data-return cycle
  always_ff @(posedge clk) begin
    if (rst || w_abort) begin
      r_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) r_vaddr[i] <= '0;
    end else begin
      r_vld[0]   <= o_rd_en;
      r_vaddr[0] <= o_rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i]   <= r_vld[i-1];
        r_vaddr[i] <= r_vaddr[i-1];
      end
    end
  end

  // Subtract with wrap, then add q back when the borrow bit is set
  always_comb begin
    w_d      = {1'b0, i_a_rdata} - {1'b0, i_b_rdata};
    w_mask   = c_ONE << r_qw;
    w_borrow = |(w_d & w_mask);
    w_sum    = w_d[DW-1:0] + r_q;
    w_r      = w_borrow ? w_sum : w_d[DW-1:0];
  end

  // Result register; wr_data holds when no write is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_abort) begin
      r_wr_en   <= 1'b0;
    end else begin
      r_wr_en <= r_vld[RD_LAT-1];
      if (r_vld[RD_LAT-1]) begin
        r_wr_addr <= r_vaddr[RD_LAT-1];
        r_wr_data <= w_r;
      end
    end
  end

  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_poly_ms_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_ms_stream
// Purpose  : Self-checking bench for poly_ms_stream, RD_LAT=1 and RD_LAT=3
//            instances run side by side against a cycle-level reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_poly_ms_stream;

  localparam int N  = 256;
  localparam int DW = 24;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 1'b0;
  logic i_abort = 1'b0;
  logic [DW-1:0] i_q = '0;
  logic [4:0] i_q_width = '0;

  logic [1:0]         rd_en, wr_en, busy, done;
  logic [1:0][AW-1:0] rd_addr, wr_addr;
  logic [1:0][DW-1:0] a_rd, b_rd, wr_data;

  logic [DW-1:0] a_mem [N];
  logic [DW-1:0] b_mem [N];
  logic [DW-1:0] res_mem [N];
  logic [1:0][DW-1:0] pa3, pb3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  poly_ms_stream #(.N(N), .DW(DW), .AW(AW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_q(i_q), .i_q_width(i_q_width),
    .o_rd_en(rd_en[0]), .o_rd_addr(rd_addr[0]),
    .i_a_rdata(a_rd[0]), .i_b_rdata(b_rd[0]),
    .o_wr_en(wr_en[0]), .o_wr_addr(wr_addr[0]), .o_wr_data(wr_data[0]),
    .o_busy(busy[0]), .o_done(done[0]));

  poly_ms_stream #(.N(N), .DW(DW), .AW(AW), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_q(i_q), .i_q_width(i_q_width),
    .o_rd_en(rd_en[1]), .o_rd_addr(rd_addr[1]),
    .i_a_rdata(a_rd[1]), .i_b_rdata(b_rd[1]),
    .o_wr_en(wr_en[1]), .o_wr_addr(wr_addr[1]), .o_wr_data(wr_data[1]),
    .o_busy(busy[1]), .o_done(done[1]));

  // Source RAMs with 1- and 3-cycle read latency; garbage when not read
  always @(posedge clk) begin
    a_rd[0] <= rd_en[0] ? a_mem[rd_addr[0]] : DW'($urandom);
    b_rd[0] <= rd_en[0] ? b_mem[rd_addr[0]] : DW'($urandom);
    pa3[0]  <= rd_en[1] ? a_mem[rd_addr[1]] : DW'($urandom);
    pb3[0]  <= rd_en[1] ? b_mem[rd_addr[1]] : DW'($urandom);
    pa3[1]  <= pa3[0];
    pb3[1]  <= pb3[0];
    a_rd[1] <= pa3[1];
    b_rd[1] <= pb3[1];
    if (wr_en[0]) res_mem[wr_addr[0]] <= wr_data[0];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: modular difference in plain integer arithmetic
  function automatic logic [31:0] ref_sub(input int a, input int b, input int q);
    return (a >= b) ? 32'(a - b) : 32'(a - b + q);
  endfunction

  task automatic fill(input int q);
    for (int i = 0; i < N; i++) begin
      a_mem[i] = DW'($urandom_range(q - 1, 0));
      b_mem[i] = DW'($urandom_range(q - 1, 0));
    end
  endtask

  // stop_kind: 0 none, 1 abort at cycle stop_t, 2 reset at cycle stop_t
  task automatic run_op(input int stop_t, input int stop_kind, input bit pulses,
                        input int q, input int qw);
    @(negedge clk);
    i_start   = 1'b1;
    i_q       = DW'(q);
    i_q_width = 5'(qw);
    @(posedge clk);
    @(negedge clk);
    i_start   = 1'b0;
    i_q       = DW'($urandom);
    i_q_width = 5'($urandom);
    for (int t = 1; t <= N + 7; t++) begin
      for (int j = 0; j < 2; j++) begin
        int  L;
        bit  stopped, e_rd, e_wr;
        int  wa;
        L       = (j == 0) ? 1 : 3;
        stopped = (stop_kind != 0) && (t > stop_t);
        e_rd    = !stopped && (t <= N);
        e_wr    = !stopped && (t >= L + 2) && (t <= N + L + 1);
        chk($sformatf("rd_en i%0d t%0d", j, t), 32'(rd_en[j]), 32'(e_rd));
        if (e_rd)
          chk($sformatf("rd_addr i%0d t%0d", j, t), 32'(rd_addr[j]), 32'(t - 1));
        else if (stop_kind != 1)
          chk($sformatf("rd_addr0 i%0d t%0d", j, t), 32'(rd_addr[j]), 32'd0);
        chk($sformatf("wr_en i%0d t%0d", j, t), 32'(wr_en[j]), 32'(e_wr));
        if (e_wr) begin
          wa = t - L - 2;
          chk($sformatf("wr_addr i%0d t%0d", j, t), 32'(wr_addr[j]), 32'(wa));
          chk($sformatf("wr_data i%0d t%0d", j, t), 32'(wr_data[j]),
              ref_sub(int'(a_mem[wa]), int'(b_mem[wa]), q));
        end
        if (stopped && stop_kind == 2) begin
          chk($sformatf("rst_wr_addr i%0d t%0d", j, t), 32'(wr_addr[j]), 32'd0);
          chk($sformatf("rst_wr_data i%0d t%0d", j, t), 32'(wr_data[j]), 32'd0);
        end
        chk($sformatf("busy i%0d t%0d", j, t), 32'(busy[j]),
            32'(!stopped && t <= N + L + 1));
        chk($sformatf("done i%0d t%0d", j, t), 32'(done[j]),
            32'(!stopped && t == N + L + 2));
      end
      i_start = pulses && (t == 10 || t == 200);
      i_abort = (stop_kind == 1) && (t == stop_t);
      rst     = (stop_kind == 2) && (t == stop_t);
      @(negedge clk);
    end
    i_start = 1'b0;
    i_abort = 1'b0;
    rst     = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("reset rd_en i%0d", j),   32'(rd_en[j]),   32'd0);
      chk($sformatf("reset rd_addr i%0d", j), 32'(rd_addr[j]), 32'd0);
      chk($sformatf("reset wr_en i%0d", j),   32'(wr_en[j]),   32'd0);
      chk($sformatf("reset wr_addr i%0d", j), 32'(wr_addr[j]), 32'd0);
      chk($sformatf("reset wr_data i%0d", j), 32'(wr_data[j]), 32'd0);
      chk($sformatf("reset busy i%0d", j),    32'(busy[j]),    32'd0);
      chk($sformatf("reset done i%0d", j),    32'(done[j]),    32'd0);
    end
    rst = 1'b0;

    // Directed coefficients plus a full random polynomial
    fill(8380417);
    a_mem[0] = 24'd5;  b_mem[0] = 24'd3;
    a_mem[1] = 24'd3;  b_mem[1] = 24'd5;
    a_mem[2] = 24'd0;  b_mem[2] = 24'd8380416;
    a_mem[3] = 24'd1234; b_mem[3] = 24'd1234;
    run_op(0, 0, 1'b0, 8380417, 23);
    chk("res0", 32'(res_mem[0]), 32'd2);
    chk("res1", 32'(res_mem[1]), 32'd8380415);
    chk("res2", 32'(res_mem[2]), 32'd1);
    chk("res3", 32'(res_mem[3]), 32'd0);

    // Start pulses during a run are ignored
    fill(8380417);
    run_op(0, 0, 1'b1, 8380417, 23);

    // Abort at rd_addr=100, then a clean run
    fill(8380417);
    run_op(101, 1, 1'b0, 8380417, 23);
    fill(8380417);
    run_op(0, 0, 1'b0, 8380417, 23);

    // Smaller modulus exercises a different borrow bit
    fill(3329);
    run_op(0, 0, 1'b0, 3329, 12);

    // Reset in DRAIN, then a clean run
    fill(8380417);
    run_op(257, 2, 1'b0, 8380417, 23);
    fill(8380417);
    run_op(0, 0, 1'b0, 8380417, 23);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
